// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared defaults, state type and sizing helper for the LJ audio serializer
package audio_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int BCLK_DIV_DEF = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/audio_bclk_gen.sv
// rtl/audio_bclk_gen.sv - bit clock divider with fall strobe; held at zero while not running
module audio_bclk_gen
    import audio_pkg::*;
#(
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic clk,
    input  logic reset_central,
    input  logic i_run,
    output logic o_bclk,
    output logic o_fall
);

    localparam int                DIV_W    = cnt_width(BCLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic             w_tick;

    assign w_tick = i_run && (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset_central || !i_run) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_bclk    <= ~r_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_bclk = r_bclk;
    // Strobe is high during the cycle whose closing edge drops bclk.
    assign o_fall = w_tick && r_bclk;

endmodule

// File: rtl/audio_lj_serializer.sv
// rtl/audio_lj_serializer.sv - left-justified stereo serializer: hold register, slot counter, shifter, FSM
module audio_lj_serializer
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic                clk,
    input  logic                reset_central,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                frame_start,
    output logic                underrun
);

    localparam int                FRAME_W    = 2 * SAMPLE_W;
    localparam int                SLOT_W     = cnt_width(FRAME_W);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FRAME_W - 1);
    localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(SAMPLE_W);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_hold_full;
    logic [SAMPLE_W-1:0]  r_hold_l;
    logic [SAMPLE_W-1:0]  r_hold_r;
    logic [FRAME_W-1:0]   r_shift;
    logic [SLOT_W-1:0]    r_slot;
    logic                 r_frame_start;
    logic                 r_underrun;

    logic                 w_run;
    logic                 w_fall;
    logic                 w_accept;
    logic                 w_frame_end;
    logic                 w_load;
    logic                 w_go_idle;

    assign w_run       = (r_state == ST_RUN);
    assign w_accept    = sample_valid && !r_hold_full;
    assign w_frame_end = w_fall && (r_slot == SLOT_LAST);

    audio_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk           (clk),
        .reset_central (reset_central),
        .i_run         (w_run),
        .o_bclk        (bclk),
        .o_fall        (w_fall)
    );

    always_ff @(posedge clk) begin
        if (reset_central) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // enable only matters while idle or on the last falling edge of a frame.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_go_idle    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && r_hold_full) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_frame_end) begin
                    if (enable) begin
                        w_load = 1'b1;
                    end else begin
                        w_go_idle    = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A load uses the hold state from before this edge; a pair accepted on
    // the same edge lands in the hold for the following frame.
    always_ff @(posedge clk) begin
        if (reset_central) begin
            r_hold_full   <= 1'b0;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_shift       <= '0;
            r_slot        <= '0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            r_underrun    <= w_load && !r_hold_full;

            if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold_l    <= sample_l;
                r_hold_r    <= sample_r;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_shift <= r_hold_full ? {r_hold_l, r_hold_r} : '0;
                r_slot  <= '0;
            end else if (w_go_idle) begin
                r_shift <= '0;
                r_slot  <= '0;
            end else if (w_fall) begin
                r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
                r_slot  <= r_slot + 1'b1;
            end
        end
    end

    assign sample_ready = !r_hold_full;
    assign lrclk        = (r_slot >= SLOT_RIGHT);
    assign sdata        = r_shift[FRAME_W-1];
    assign frame_start  = r_frame_start;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_audio_lj_serializer.sv
// tb/tb_audio_lj_serializer.sv - self-checking bench: vector table, corner sequences, random traffic vs frame model
module tb_audio_lj_serializer;

    localparam int W         = 16;
    localparam int DIV       = 2;
    localparam int FW        = 2 * W;
    localparam int FRAME_CLK = 2 * DIV * FW;

    logic          clk           = 1'b0;
    logic          reset_central = 1'b1;
    logic          enable        = 1'b0;
    logic [W-1:0]  sample_l      = '0;
    logic [W-1:0]  sample_r      = '0;
    logic          sample_valid  = 1'b0;
    logic          sample_ready;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          frame_start;
    logic          underrun;

    audio_lj_serializer #(
        .SAMPLE_W (W),
        .BCLK_DIV (DIV)
    ) dut (
        .clk           (clk),
        .reset_central (reset_central),
        .enable        (enable),
        .sample_l      (sample_l),
        .sample_r      (sample_r),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .sdata         (sdata),
        .frame_start   (frame_start),
        .underrun      (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  l;
        logic [W-1:0]  r;
        logic [FW-1:0] exp_bits;
    } vec_t;

    typedef struct {
        logic [FW-1:0] pair;
        int            cyc;
    } acc_t;

    vec_t          tbl [4];
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    acc_t          acc_q [$];
    logic [FW-1:0] cap_q [$];
    int            fs_q  [$];
    logic          ur_q  [$];
    logic          in_frame  = 1'b0;
    int            nbits     = 0;
    logic [FW-1:0] bits      = '0;
    logic [FW-1:0] exp_frame = '0;
    int            start_cyc = 0;
    int            last_rise = 0;
    logic          prev_bclk = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted pairs queue up in order; a frame plays the
    // oldest pair accepted at least one edge before its load, otherwise silence.
    task automatic monitor();
        logic exp_ur;
        acc_t a;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_central) begin
                acc_q.delete();
                in_frame  = 1'b0;
                prev_bclk = 1'b0;
            end else begin
                if (frame_start) begin
                    check("frame_cut_short", in_frame, 0);
                    exp_ur = !(acc_q.size() > 0 && acc_q[0].cyc <= cyc - 2);
                    check("underrun_flag", underrun, exp_ur);
                    if (exp_ur) begin
                        exp_frame = '0;
                    end else begin
                        a = acc_q.pop_front();
                        exp_frame = a.pair;
                    end
                    in_frame  = 1'b1;
                    nbits     = 0;
                    start_cyc = cyc;
                    fs_q.push_back(cyc);
                    ur_q.push_back(underrun);
                end else begin
                    check("underrun_without_load", underrun, 0);
                end
                if (bclk && !prev_bclk) begin
                    check("rise_inside_frame", in_frame, 1);
                    if (in_frame) begin
                        if (nbits == 0) check("first_rise_delay", cyc - start_cyc, DIV);
                        else            check("rise_spacing", cyc - last_rise, 2 * DIV);
                        check("lrclk_slot", lrclk, nbits >= W);
                        check("sdata_bit", sdata, exp_frame[FW-1-nbits]);
                        bits = {bits[FW-2:0], sdata};
                        nbits++;
                        last_rise = cyc;
                        if (nbits == FW) begin
                            cap_q.push_back(bits);
                            in_frame = 1'b0;
                        end
                    end
                end
                prev_bclk = bclk;
                check("sample_ready", sample_ready, acc_q.size() == 0);
                if (sample_valid && sample_ready) acc_q.push_back('{{sample_l, sample_r}, cyc});
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
        logic got;
        int   k;
        got = 1'b0;
        k   = 0;
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        while (!got && k < 400) begin
            @(negedge clk);
            got = sample_ready;
            tick(1);
            k++;
        end
        sample_valid = 1'b0;
        check("send_accepted", got, 1);
    endtask

    task automatic wait_caps(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (cap_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(name, cap_q.size() >= n, 1);
    endtask

    task automatic wait_fs(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (fs_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(name, fs_q.size() >= n, 1);
    endtask

    task automatic wait_bits(input int s, input int budget, input string name);
        int k;
        k = 0;
        while (!(in_frame && nbits >= s) && k < budget) begin
            tick(1);
            k++;
        end
        check(name, in_frame && nbits >= s, 1);
    endtask

    task automatic quiet(input int n, input string name);
        logic act;
        act = 1'b0;
        repeat (n) begin
            @(negedge clk);
            act = act | bclk | lrclk | sdata | frame_start | underrun;
        end
        tick(1);
        check(name, act, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bclk"},  bclk, 0);
        check({tag, "_lrclk"}, lrclk, 0);
        check({tag, "_sdata"}, sdata, 0);
        check({tag, "_fs"},    frame_start, 0);
        check({tag, "_ur"},    underrun, 0);
        check({tag, "_ready"}, sample_ready, 1);
    endtask

    initial begin
        int            cb;
        int            fb;
        int            f0;
        logic [FW-1:0] p;

        tbl[0] = '{16'hA5F0, 16'h0F0F, 32'b1010_0101_1111_0000_0000_1111_0000_1111};
        tbl[1] = '{16'h8000, 16'h0001, 32'h8000_0001};
        tbl[2] = '{16'hFFFF, 16'h0000, 32'hFFFF_0000};
        tbl[3] = '{16'h1234, 16'hFEDC, 32'h1234_FEDC};

        fork
            monitor();
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation did not reach the end");
                $fatal(1);
            end
        join_none

        // Reset, then enabled with no data: nothing moves.
        reset_central = 1'b1;
        tick(3);
        reset_central = 1'b0;
        check_reset_outputs("reset");
        enable = 1'b1;
        quiet(40, "idle_no_data");

        // Vector table fed back-to-back, followed by one underrun frame.
        cb = cap_q.size();
        fb = fs_q.size();
        for (int i = 0; i < 4; i++) send(tbl[i].l, tbl[i].r);
        wait_caps(cb + 5, 1200, "table_frames");
        if (cap_q.size() >= cb + 5) begin
            for (int i = 0; i < 4; i++) begin
                check("table_frame", cap_q[cb+i], tbl[i].exp_bits);
                check("table_no_underrun", ur_q[fb+i], 0);
                check("table_frame_period", fs_q[fb+i+1] - fs_q[fb+i], FRAME_CLK);
            end
            check("underrun_frame_zero", cap_q[cb+4], 0);
            check("underrun_pulse", ur_q[fb+4], 1);
        end
        enable = 1'b0;
        tick(300);
        quiet(20, "stopped_idle");

        // Stop mid-frame: frame completes, held pair waits for enable.
        cb = cap_q.size();
        fb = fs_q.size();
        send(16'h1357, 16'h9BDF);
        quiet(30, "hold_waits_for_enable");
        enable = 1'b1;
        wait_fs(fb + 1, 20, "stop_frame_start");
        send(16'h2468, 16'hACE0);
        wait_bits(5, 100, "stop_slot5");
        enable = 1'b0;
        wait_caps(cb + 1, 200, "stop_frame_done");
        tick(2 * DIV);
        quiet(40, "stop_idle");
        check("stop_no_restart", fs_q.size(), fb + 1);
        if (cap_q.size() > cb) check("stop_frame_data", cap_q[cb], 32'h1357_9BDF);
        enable = 1'b1;
        wait_fs(fb + 2, 20, "restart_frame_start");
        enable = 1'b0;
        wait_caps(cb + 2, 200, "restart_frame_done");
        if (cap_q.size() > cb + 1) check("restart_frame_data", cap_q[cb+1], 32'h2468_ACE0);
        if (ur_q.size() > fb + 1) check("restart_no_underrun", ur_q[fb+1], 0);
        tick(2 * DIV);
        quiet(20, "restart_stop_idle");

        // Reset at slot 10 with a pair waiting in the hold.
        enable = 1'b1;
        fb = fs_q.size();
        send(16'hCAFE, 16'hBEEF);
        wait_fs(fb + 1, 20, "pre_reset_frame_start");
        send(16'h0BAD, 16'hF00D);
        wait_bits(10, 100, "reset_slot10");
        reset_central = 1'b1;
        tick(1);
        reset_central = 1'b0;
        check_reset_outputs("midreset");
        quiet(40, "reset_drops_hold");
        cb = cap_q.size();
        fb = fs_q.size();
        send(16'h7E57, 16'h0123);
        wait_caps(cb + 1, 200, "after_reset_frame");
        if (cap_q.size() > cb) check("after_reset_data", cap_q[cb], 32'h7E57_0123);

        // Accept on the very edge that loads an underrun frame.
        wait_fs(fb + 2, 20, "underrun_stream_start");
        if (fs_q.size() >= fb + 2) begin
            f0 = fs_q[fb+1];
            while (cyc < f0 + FRAME_CLK - 2) tick(1);
            p = 32'h5A5A_C3C3;
            sample_l     = p[FW-1:W];
            sample_r     = p[W-1:0];
            sample_valid = 1'b1;
            tick(1);
            sample_valid = 1'b0;
            wait_caps(cb + 4, 400, "edge_accept_frames");
            if (cap_q.size() >= cb + 4 && fs_q.size() >= fb + 4) begin
                check("edge_load_period", fs_q[fb+2] - f0, FRAME_CLK);
                check("edge_load_underrun", ur_q[fb+2], 1);
                check("edge_load_zero", cap_q[cb+2], 0);
                check("edge_next_no_underrun", ur_q[fb+3], 0);
                check("edge_next_data", cap_q[cb+3], p);
            end
        end

        // Random traffic with random enable gaps, checked by the monitor model.
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                enable = 1'b0;
                tick($urandom_range(1, 200));
            end
            enable = 1'b1;
            tick($urandom_range(0, 140));
            send(W'($urandom), W'($urandom));
        end
        tick(300);
        enable = 1'b0;
        tick(300);
        quiet(20, "final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
